// File: rtl/mips_inst_pkg.sv
// Shared MiniMIPS32 instruction field definitions and fetch-queue entry layout.
package mips_inst_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned FUNC_MSB = 5;
    localparam int unsigned FUNC_LSB = 0;

    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;

    // One queue entry as seen by ID
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              excp;
    } inst_entry_t;

    // Opcode field of an instruction word
    function automatic logic [OP_W-1:0] op_of(input logic [INST_W-1:0] inst);
        return inst[OP_MSB:OP_LSB];
    endfunction

    // Function field of an instruction word
    function automatic logic [FUNC_W-1:0] func_of(input logic [INST_W-1:0] inst);
        return inst[FUNC_MSB:FUNC_LSB];
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Fetch-queue storage: register array, one synchronous write port, one combinational read port.
module inst_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 65
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// IF->ID instruction fetch queue: circular FIFO of {pc, inst, excp} with op/func pre-split.
// Optional macro INST_QUEUE_BYPASS_EN: empty-queue zero-latency bypass from in_* to out_*.
module inst_fetch_queue
    import mips_inst_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                   cpu_clk_50M,
    input  logic                   cpu_rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_pc,
    input  logic [31:0]            in_inst,
    input  logic                   in_excp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_pc,
    output logic [31:0]            out_inst,
    output logic [5:0]             out_op,
    output logic [5:0]             out_func,
    output logic                   out_excp,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + INST_W + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              fifo_valid;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_en;
    logic              byp_pass;
    logic [EW-1:0]     rdata;
    logic              head_valid;
    logic [AW-1:0]     head_pc;
    logic [INST_W-1:0] head_inst;
    logic              head_excp;

    assign in_ready   = (count != CW'(DEPTH));
    assign fifo_valid = (count != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    // A bypassed entry is consumed directly and never occupies a slot
    assign wr_en      = push & ~byp_pass;
    assign rd_en      = pop & fifo_valid;

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk   (cpu_clk_50M),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_inst, in_excp}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

`ifdef INST_QUEUE_BYPASS_EN
    logic byp_sel;
    assign byp_sel  = ~fifo_valid & ~flush;
    assign byp_pass = byp_sel & in_valid & out_ready;

    // Head source: incoming instruction when the queue is empty, else storage
    always_comb begin
        head_valid = fifo_valid;
        {head_pc, head_inst, head_excp} = rdata;
        if (byp_sel) begin
            head_valid = in_valid;
            head_pc    = in_pc;
            head_inst  = in_inst;
            head_excp  = in_excp;
        end
    end
`else
    assign byp_pass = 1'b0;

    // Head source: always the storage entry at rd_ptr
    always_comb begin
        head_valid = fifo_valid;
        {head_pc, head_inst, head_excp} = rdata;
    end
`endif

    // Invalid head presents a NOP with zero pc and no exception
    always_comb begin
        out_valid = head_valid;
        out_pc    = '0;
        out_inst  = INST_NOP;
        out_excp  = 1'b0;
        if (head_valid) begin
            out_pc   = head_pc;
            out_inst = head_inst;
            out_excp = head_excp;
        end
    end

    assign out_op   = op_of(out_inst);
    assign out_func = func_of(out_inst);

    // Pointer and occupancy update; reset and flush override any transfer
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4, AW=32); covers INST_QUEUE_BYPASS_EN builds too.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_excp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [5:0]  out_op;
    logic [5:0]  out_func;
    logic        out_excp;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    inst_fetch_queue #(.DEPTH(4), .AW(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_excp     (in_excp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_op      (out_op),
        .out_func    (out_func),
        .out_excp    (out_excp),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r, f, iv;
        logic [31:0] pc, inst;
        logic        ex, ordy;
        logic        eov, eir;
        logic [2:0]  ecnt;
        logic [31:0] epc, einst;
        logic        eex;
    } vec_t;

    function automatic vec_t mk(input logic r, f, iv, input logic [31:0] pc, inst,
                                input logic ex, ordy, eov, eir, input logic [2:0] ecnt,
                                input logic [31:0] epc, einst, input logic eex);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ex = ex; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.ecnt = ecnt; v.epc = epc; v.einst = einst; v.eex = eex;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    endtask

    task automatic drive(input logic r, f, iv, input logic [31:0] pc, inst, input logic ex, ordy);
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; in_excp = ex; out_ready = ordy;
    endtask

    vec_t tv[24];

    initial begin
        tv[0]  = mk(0,0,0, 32'h0,        32'h0,        0,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[1]  = mk(0,0,1, 32'hBFC0_0000,32'h2408_0005,0,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[2]  = mk(0,0,0, 32'h0,        32'h0,        0,0, 1,1,1, 32'hBFC0_0000,32'h2408_0005,0);
        tv[3]  = mk(0,0,1, 32'h4,        32'h8C01_0004,0,0, 1,1,1, 32'hBFC0_0000,32'h2408_0005,0);
        tv[4]  = mk(0,0,1, 32'h8,        32'h0022_1820,0,0, 1,1,2, 32'hBFC0_0000,32'h2408_0005,0);
        tv[5]  = mk(0,0,1, 32'hC,        32'h1000_0003,0,0, 1,1,3, 32'hBFC0_0000,32'h2408_0005,0);
        tv[6]  = mk(0,0,1, 32'h10,       32'hAC03_0008,0,0, 1,0,4, 32'hBFC0_0000,32'h2408_0005,0);
        tv[7]  = mk(0,0,1, 32'h10,       32'hAC03_0008,0,1, 1,0,4, 32'hBFC0_0000,32'h2408_0005,0);
        tv[8]  = mk(0,0,0, 32'h0,        32'h0,        0,1, 1,1,3, 32'h4,        32'h8C01_0004,0);
        tv[9]  = mk(0,0,0, 32'h0,        32'h0,        0,1, 1,1,2, 32'h8,        32'h0022_1820,0);
        tv[10] = mk(0,0,0, 32'h0,        32'h0,        0,1, 1,1,1, 32'hC,        32'h1000_0003,0);
        tv[11] = mk(0,0,0, 32'h0,        32'h0,        0,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[12] = mk(0,0,1, 32'h100,      32'h1111_1111,0,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[13] = mk(0,0,1, 32'h104,      32'h2222_2222,0,0, 1,1,1, 32'h100,      32'h1111_1111,0);
        tv[14] = mk(0,0,1, 32'h108,      32'h3333_3333,0,0, 1,1,2, 32'h100,      32'h1111_1111,0);
        tv[15] = mk(0,1,1, 32'h10C,      32'h4444_4444,0,0, 1,1,3, 32'h100,      32'h1111_1111,0);
        tv[16] = mk(0,0,0, 32'h0,        32'h0,        0,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[17] = mk(0,0,1, 32'h200,      32'h0,        1,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[18] = mk(0,0,1, 32'h204,      32'h03E0_0008,0,0, 1,1,1, 32'h200,      32'h0,        1);
        tv[19] = mk(1,0,0, 32'h0,        32'h0,        0,0, 1,1,2, 32'h200,      32'h0,        1);
        tv[20] = mk(0,0,0, 32'h0,        32'h0,        0,1, 0,1,0, 32'h0,        32'h0,        0);
        tv[21] = mk(0,0,1, 32'h300,      32'h2408_0005,0,0, 0,1,0, 32'h0,        32'h0,        0);
        tv[22] = mk(0,0,0, 32'h0,        32'h0,        0,1, 1,1,1, 32'h300,      32'h2408_0005,0);
        tv[23] = mk(0,0,0, 32'h0,        32'h0,        0,0, 0,1,0, 32'h0,        32'h0,        0);

        drive(1,0,0,32'h0,32'h0,0,0);
        repeat (2) @(posedge clk);
        #1;

        // Table: inputs held for one cycle, outputs sampled on the falling edge
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            logic [31:0] ei;
            v = tv[i];
`ifdef INST_QUEUE_BYPASS_EN
            if (v.ecnt == 3'd0 && v.iv && !v.f) begin
                v.eov = 1'b1; v.epc = v.pc; v.einst = v.inst; v.eex = v.ex;
            end
`endif
            drive(v.r, v.f, v.iv, v.pc, v.inst, v.ex, v.ordy);
            @(negedge clk);
            ei = v.einst;
            chk("out_valid", i, 32'(out_valid), 32'(v.eov));
            chk("in_ready",  i, 32'(in_ready),  32'(v.eir));
            chk("count",     i, 32'(count),     32'(v.ecnt));
            chk("out_pc",    i, out_pc,         v.epc);
            chk("out_inst",  i, out_inst,       v.einst);
            chk("out_op",    i, 32'(out_op),    32'(ei[31:26]));
            chk("out_func",  i, 32'(out_func),  32'(ei[5:0]));
            chk("out_excp",  i, 32'(out_excp),  32'(v.eex));
            @(posedge clk);
            #1;
        end

        // Streaming at occupancy 2: pointers wrap, head PCs ascend by 4
        drive(0,0,1,32'h0,32'hA000_0000,0,0);
        @(posedge clk); #1;
        drive(0,0,1,32'h4,32'hA000_0004,0,0);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            drive(0,0,1,32'(8 + 4*i),32'hA000_0000 | 32'(8 + 4*i),0,1);
            @(negedge clk);
            chk("stream_count", i, 32'(count), 32'd2);
            chk("stream_pc",    i, out_pc,     32'(4*i));
            chk("stream_inst",  i, out_inst,   32'hA000_0000 | 32'(4*i));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            drive(0,0,0,32'h0,32'h0,0,1);
            @(negedge clk);
            chk("drain_pc", i, out_pc, 32'(40 + 4*i));
            @(posedge clk); #1;
        end
        drive(0,0,0,32'h0,32'h0,0,0);
        @(negedge clk);
        chk("drain_count", 0, 32'(count), 32'd0);
        chk("drain_valid", 0, 32'(out_valid), 32'd0);
        @(posedge clk); #1;

`ifdef INST_QUEUE_BYPASS_EN
        // Empty-queue pass-through: visible the same cycle, never stored
        drive(0,0,1,32'h400,32'h0000_0008,0,1);
        @(negedge clk);
        chk("byp_valid", 0, 32'(out_valid), 32'd1);
        chk("byp_func",  0, 32'(out_func),  32'h08);
        chk("byp_pc",    0, out_pc,         32'h400);
        @(posedge clk); #1;
        drive(0,0,0,32'h0,32'h0,0,1);
        @(negedge clk);
        chk("byp_count", 0, 32'(count),     32'd0);
        chk("byp_after", 0, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
